// File: rtl/gate_test_pkg.sv
// Shared definitions for the quad 2-input gate tester: sequencer states,
// gate codes understood by the reference gate selector, and vector count.
package gate_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    localparam logic [2:0] GATE_AND  = 3'b000;
    localparam logic [2:0] GATE_OR   = 3'b001;
    localparam logic [2:0] GATE_NAND = 3'b010;
    localparam logic [2:0] GATE_NOR  = 3'b011;
    localparam logic [2:0] GATE_XOR  = 3'b100;
    localparam logic [2:0] GATE_XNOR = 3'b101;

    localparam int VEC_COUNT = 4;

    // Codes 110 and 111 have no reference gate behind them.
    function automatic logic is_valid_gate(input logic [2:0] code);
        return (code <= GATE_XNOR);
    endfunction

endpackage

// File: rtl/gate_test_settle_timer.sv
// Down-counter that times how long a test vector settles before the
// gate outputs are sampled.
module settle_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] value,
    output logic       expired
);

    logic [7:0] count;

    // Counts down from the loaded value and parks at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= value;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    // The last settle cycle is the one that still shows a count of one.
    assign expired = (count == 8'd1);

endmodule

// File: rtl/gate_test_sequencer.sv
// Walks a quad 2-input gate IC through all four input combinations and
// compares every gate output against the reference gate.
module gate_test_sequencer
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] ic_type,
    input  logic       ref_y,
    input  logic [3:0] dut_y,
    output logic [2:0] sel,
    output logic [3:0] vec_a,
    output logic [3:0] vec_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] gate_fail,
    output logic       error
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [1:0] LAST_IDX    = 2'(VEC_COUNT - 1);

    state_t     state;
    logic [1:0] idx;
    logic [1:0] next_idx;
    logic       settle_expired;

    assign next_idx = idx + 2'd1;

    settle_timer u_settle_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (state == ST_APPLY),
        .value   (SETTLE_LOAD),
        .expired (settle_expired)
    );

    // Vector registers only change on the way into APPLY (or back to zero
    // on the way into DONE), so the IC sees a stable input while it settles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sel       <= 3'b000;
            vec_a     <= 4'b0000;
            vec_b     <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            gate_fail <= 4'b0000;
            error     <= 1'b0;
            idx       <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        gate_fail <= 4'b0000;
                        if (is_valid_gate(ic_type)) begin
                            sel   <= ic_type;
                            error <= 1'b0;
                            idx   <= 2'd0;
                            vec_a <= 4'b0000;
                            vec_b <= 4'b0000;
                            state <= ST_APPLY;
                        end else begin
                            error <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end

                ST_APPLY: begin
                    state <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (settle_expired) begin
                        state <= ST_COMPARE;
                    end
                end

                ST_COMPARE: begin
                    gate_fail <= gate_fail | (dut_y ^ {4{ref_y}});
                    if (idx == LAST_IDX) begin
                        vec_a <= 4'b0000;
                        vec_b <= 4'b0000;
                        state <= ST_DONE;
                    end else begin
                        idx   <= next_idx;
                        vec_a <= {4{next_idx[1]}};
                        vec_b <= {4{next_idx[0]}};
                        state <= ST_APPLY;
                    end
                end

                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (gate_fail == 4'b0000) && !error;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
